// File: rtl/unit_fault_pkg.sv
// Shared types and constants for the unit fault manager: the first-fault
// FSM state encoding and the trip counter width.
package unit_fault_pkg;

    localparam int TRIP_W = 8;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CAPTURED = 1'b1
    } ff_state_e;

endpackage

// File: rtl/fault_deb_ch.sv
// One fault channel: symmetric debounce of the raw fault against the 1 us
// strobe, then either a latched or a self-clearing status bit.
module fault_deb_ch #(
    parameter int DEB_W   = 14,
    parameter bit LATCHED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_strobe,
    input  logic             i_raw,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [DEB_W-1:0] i_delay,
    output logic             o_err
);

    logic [DEB_W-1:0] r_cnt;
    logic             r_flag;
    logic             r_err;
    logic [DEB_W-1:0] w_limit;
    logic [DEB_W:0]   w_cnt_inc;
    logic             w_active;
    logic             w_err_nxt;

    // A zero length still needs one strobe to trip.
    assign w_limit   = (i_delay == '0) ? DEB_W'(1) : i_delay;
    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
    // The counter only runs while the raw input disagrees with the flag.
    assign w_active  = i_raw ^ r_flag;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (!w_active) begin
            r_cnt  <= '0;
        end else if (i_strobe) begin
            if (w_cnt_inc >= {1'b0, w_limit}) begin
                r_flag <= ~r_flag;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= w_cnt_inc[DEB_W-1:0];
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_err_nxt = r_err;
        if (!i_en) begin
            w_err_nxt = 1'b0;
        end else if (!LATCHED) begin
            w_err_nxt = r_flag;
        end else if (r_flag) begin
            w_err_nxt = 1'b1;
        end else if (i_clr) begin
            w_err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= w_err_nxt;
    end

    assign o_err = r_err;

endmodule

// File: rtl/unit_fault_mgr.sv
// Unit fault manager: N_CH debounced fault channels, a first-fault recorder,
// and a saturating trip counter on the unit-level error.
module unit_fault_mgr
    import unit_fault_pkg::*;
#(
    parameter int              N_CH       = 12,
    parameter int              DEB_W      = 14,
    parameter logic [N_CH-1:0] LATCH_MASK = '1,
    localparam int             IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              time_1us,
    input  logic              reset_unit,
    input  logic [N_CH-1:0]   fault_raw,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic [DEB_W-1:0]  delay_tims,
    output logic [N_CH-1:0]   err_info,
    output logic              err_unit,
    output logic              first_valid,
    output logic [IDX_W-1:0]  first_idx,
    output logic [TRIP_W-1:0] trip_cnt
);

    logic              r_rst_unit_d;
    logic              r_clr_pend;
    logic [N_CH-1:0]   r_err_prev;
    logic              r_err_unit;
    logic [IDX_W-1:0]  r_first_idx;
    logic [TRIP_W-1:0] r_trip_cnt;
    ff_state_e         r_state;
    ff_state_e         w_state_nxt;
    logic              w_capture;
    logic              w_clr;
    logic              w_err_any;
    logic [N_CH-1:0]   w_rise;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_CH-1:0] v);
        lowest_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    assign w_clr     = reset_unit & ~r_rst_unit_d;
    assign w_err_any = |err_info;
    assign w_rise    = err_info & ~r_err_prev;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        fault_deb_ch #(
            .DEB_W   (DEB_W),
            .LATCHED (LATCH_MASK[g])
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_strobe (time_1us),
            .i_raw    (fault_raw[g]),
            .i_en     (ch_mask[g]),
            .i_clr    (w_clr),
            .i_delay  (delay_tims),
            .o_err    (err_info[g])
        );
    end

    // Leaving CAPTURED is judged one clk after the clear, once the channels
    // have applied it to err_info.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_rise) begin
                    w_state_nxt = ST_CAPTURED;
                    w_capture   = 1'b1;
                end
            end
            ST_CAPTURED: begin
                if (r_clr_pend && !w_err_any) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rst_unit_d <= 1'b0;
            r_clr_pend   <= 1'b0;
            r_err_prev   <= '0;
            r_err_unit   <= 1'b0;
            r_first_idx  <= '0;
            r_trip_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rst_unit_d <= reset_unit;
            r_clr_pend   <= w_clr;
            r_err_prev   <= err_info;
            r_err_unit   <= w_err_any;
            if (w_capture) r_first_idx <= lowest_idx(w_rise);
            if (w_err_any && !r_err_unit && (r_trip_cnt != '1)) begin
                r_trip_cnt <= r_trip_cnt + 1'b1;
            end
        end
    end

    assign err_unit    = r_err_unit;
    assign first_valid = (r_state == ST_CAPTURED);
    assign first_idx   = r_first_idx;
    assign trip_cnt    = r_trip_cnt;

endmodule

// File: tb/tb_unit_fault_mgr.sv
// Directed bench for unit_fault_mgr: debounce timing, latching, first-fault
// capture, trip saturation and asynchronous reset.
module tb_unit_fault_mgr;

    localparam int N_CH  = 12;
    localparam int DEB_W = 14;
    localparam int IDX_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              time_1us;
    logic              reset_unit;
    logic [N_CH-1:0]   fault_raw;
    logic [N_CH-1:0]   ch_mask;
    logic [DEB_W-1:0]  delay_tims;
    logic [N_CH-1:0]   err_info;
    logic              err_unit;
    logic              first_valid;
    logic [IDX_W-1:0]  first_idx;
    logic [7:0]        trip_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    unit_fault_mgr #(
        .N_CH       (N_CH),
        .DEB_W      (DEB_W),
        .LATCH_MASK (12'hFDF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .time_1us    (time_1us),
        .reset_unit  (reset_unit),
        .fault_raw   (fault_raw),
        .ch_mask     (ch_mask),
        .delay_tims  (delay_tims),
        .err_info    (err_info),
        .err_unit    (err_unit),
        .first_valid (first_valid),
        .first_idx   (first_idx),
        .trip_cnt    (trip_cnt)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 1 us period is compressed to four clocks; the strobe is the first.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) time_1us = 1'b1;
            @(negedge clk) time_1us = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic pulse_reset_unit();
        @(negedge clk) reset_unit = 1'b1;
        @(negedge clk) reset_unit = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        time_1us   = 1'b0;
        reset_unit = 1'b0;
        fault_raw  = '0;
        ch_mask    = '1;
        delay_tims = 14'd1000;
        repeat (3) @(negedge clk);
        check("rst_err_info", 32'(err_info), 32'h0);
        check("rst_trip_cnt", 32'(trip_cnt), 32'h0);
        check("rst_first_valid", 32'(first_valid), 32'h0);
        rst_n = 1'b1;

        // Long debounce: 999 strobes is one short, the 1000th trips.
        fault_raw[3] = 1'b1;
        tick(999);
        check("deb999_err_info", 32'(err_info), 32'h0);
        tick(1);
        check("deb1000_err_info", 32'(err_info), 32'h008);
        check("deb1000_err_unit", 32'(err_unit), 32'h1);
        check("deb1000_first_idx", 32'(first_idx), 32'h3);
        check("deb1000_first_valid", 32'(first_valid), 32'h1);
        check("deb1000_trip_cnt", 32'(trip_cnt), 32'h1);

        // Latched channel cannot be cleared while its flag is still set.
        pulse_reset_unit();
        check("latch_raw_high_hold", 32'(err_info), 32'h008);
        delay_tims   = 14'd5;
        fault_raw[3] = 1'b0;
        tick(4);
        pulse_reset_unit();
        check("latch_low4_hold", 32'(err_info), 32'h008);
        check("latch_low4_valid", 32'(first_valid), 32'h1);
        tick(1);
        pulse_reset_unit();
        check("latch_cleared", 32'(err_info), 32'h0);
        check("latch_cleared_valid", 32'(first_valid), 32'h0);
        check("latch_cleared_err_unit", 32'(err_unit), 32'h0);

        // A raw drop without any strobe still zeroes the count.
        fault_raw[2] = 1'b1;
        tick(4);
        @(negedge clk) fault_raw[2] = 1'b0;
        @(negedge clk);
        // Two channels rising together: lowest index wins.
        fault_raw[2] = 1'b1;
        fault_raw[7] = 1'b1;
        tick(4);
        check("dual_pre_err_info", 32'(err_info), 32'h0);
        tick(1);
        check("dual_err_info", 32'(err_info), 32'h084);
        check("dual_first_idx", 32'(first_idx), 32'h2);
        check("dual_trip_cnt", 32'(trip_cnt), 32'h2);
        fault_raw = '0;
        tick(5);
        pulse_reset_unit();
        check("dual_cleared", 32'(err_info), 32'h0);
        check("dual_cleared_valid", 32'(first_valid), 32'h0);

        // Self-clearing channel 5 follows its debounced flag both ways.
        delay_tims   = 14'd10;
        fault_raw[5] = 1'b1;
        tick(9);
        check("sc_rise9", 32'(err_info), 32'h0);
        tick(1);
        check("sc_rise10", 32'(err_info), 32'h020);
        check("sc_first_idx", 32'(first_idx), 32'h5);
        tick(10);
        fault_raw[5] = 1'b0;
        tick(9);
        check("sc_fall9", 32'(err_info), 32'h020);
        tick(1);
        check("sc_fall10", 32'(err_info), 32'h0);
        check("sc_valid_held", 32'(first_valid), 32'h1);
        check("sc_trip_cnt", 32'(trip_cnt), 32'h3);
        pulse_reset_unit();
        check("sc_valid_cleared", 32'(first_valid), 32'h0);

        // delay_tims = 0 behaves as 1; masking overrides a latched bit.
        delay_tims   = 14'd0;
        fault_raw[0] = 1'b1;
        tick(1);
        check("d0_err_info", 32'(err_info), 32'h001);
        check("d0_first_idx", 32'(first_idx), 32'h0);
        @(negedge clk) ch_mask[0] = 1'b0;
        @(negedge clk);
        check("mask_clears_latched", 32'(err_info), 32'h0);
        fault_raw[0] = 1'b0;
        ch_mask[0]   = 1'b1;
        pulse_reset_unit();
        check("mask_valid_cleared", 32'(first_valid), 32'h0);
        check("mask_trip_cnt", 32'(trip_cnt), 32'h4);

        // Shrinking delay_tims below the running count trips on the next strobe.
        delay_tims   = 14'd10;
        fault_raw[1] = 1'b1;
        tick(6);
        check("dchg_pre", 32'(err_info), 32'h0);
        delay_tims = 14'd4;
        tick(1);
        check("dchg_trip", 32'(err_info), 32'h002);
        fault_raw[1] = 1'b0;
        tick(4);
        pulse_reset_unit();
        check("dchg_cleared", 32'(err_info), 32'h0);
        check("dchg_trip_cnt", 32'(trip_cnt), 32'h5);

        // Trip counter saturation on repeated self-clearing trips.
        delay_tims = 14'd0;
        for (int i = 0; i < 100; i++) begin
            fault_raw[5] = 1'b1;
            tick(1);
            fault_raw[5] = 1'b0;
            tick(1);
        end
        check("trip_105", 32'(trip_cnt), 32'd105);
        for (int i = 0; i < 200; i++) begin
            fault_raw[5] = 1'b1;
            tick(1);
            fault_raw[5] = 1'b0;
            tick(1);
        end
        check("trip_sat", 32'(trip_cnt), 32'd255);
        pulse_reset_unit();
        check("trip_kept_by_clear", 32'(trip_cnt), 32'd255);

        // Asynchronous reset in the middle of a debounce.
        fault_raw[6] = 1'b1;
        tick(1);
        check("pre_rst_err_info", 32'(err_info), 32'h040);
        delay_tims   = 14'd10;
        fault_raw[4] = 1'b1;
        tick(5);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_err_info", 32'(err_info), 32'h0);
        check("arst_err_unit", 32'(err_unit), 32'h0);
        check("arst_first_valid", 32'(first_valid), 32'h0);
        check("arst_first_idx", 32'(first_idx), 32'h0);
        check("arst_trip_cnt", 32'(trip_cnt), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick(9);
        check("post_rst9", 32'(err_info), 32'h0);
        tick(1);
        check("post_rst10", 32'(err_info), 32'h050);
        check("post_rst_first_idx", 32'(first_idx), 32'h4);
        check("post_rst_trip_cnt", 32'(trip_cnt), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
